// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one command at a time from the execute stage, one word-wide
// memory request per aligned command, response lane extraction and
// sign/zero extension for loads, and a register-file write for loads.
//
// Handshakes: every channel uses valid/ready. A transfer happens on the rising
// edge where both are high. The sender keeps valid and its payload stable until
// that edge. The receiver may raise or drop ready freely.
//   in_*       : execute stage -> LSU; in_ready is high only in IDLE.
//   mem_req_*  : LSU -> memory; the payload comes from latched fields only.
//   mem_resp_* : memory -> LSU; ready is high only in WAIT, so a response
//                offered in any other state is never consumed.
module ysyx_24100005_lsu #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_addr,
    input  logic [DATA_WIDTH-1:0]    in_wdata,
    input  logic                     in_is_store,
    input  logic                     in_unsigned,
    input  logic [1:0]               in_size,
    input  logic [RF_ADDR_WIDTH-1:0] in_rd,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [DATA_WIDTH-1:0]    mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    output logic                     mem_req_wen,
    output logic [3:0]               mem_req_wmask,

    input  logic                     mem_resp_valid,
    output logic                     mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]    mem_resp_rdata,

    output logic                     rf_wen,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,

    output logic                     done,
    output logic                     err,

    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched command fields
    logic [DATA_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     is_store_q;
    logic                     unsigned_q;
    logic [1:0]               size_q;
    logic [RF_ADDR_WIDTH-1:0] rd_q;

    // Registered response word, consumed in WB
    logic [DATA_WIDTH-1:0]    rdata_q;

    // Registered one-cycle pulses
    logic                     store_done_q;
    logic                     err_q;

    // Decoded helpers
    logic                     accept;
    logic                     misaligned;
    logic [3:0]               st_mask;
    logic [DATA_WIDTH-1:0]    st_data;
    logic [DATA_WIDTH-1:0]    ld_lane;
    logic [DATA_WIDTH-1:0]    ld_data;

    assign accept = in_valid && (state == S_IDLE);

    // Alignment check on the incoming command; size 3 is never legal
    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a misaligned command is consumed and stays in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && !misaligned) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = is_store_q ? S_IDLE : S_WB;
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            rd_q       <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                is_store_q <= in_is_store;
                unsigned_q <= in_unsigned;
                size_q     <= in_size;
                rd_q       <= in_rd;
            end
            if ((state == S_WAIT) && mem_resp_valid) begin
                rdata_q <= mem_resp_rdata;
            end
        end
    end

    // Completion pulses for the paths that return straight to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            store_done_q <= (state == S_WAIT) && mem_resp_valid && is_store_q;
            err_q        <= accept && misaligned;
        end
    end

    // Store lane mask and replicated store data
    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata_q;
        case (size_q)
            2'd0: begin
                st_mask = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                st_mask = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    // Load lane extraction and extension from the registered response
    always_comb begin
        ld_lane = rdata_q >> {addr_q[1:0], 3'b000};
        ld_data = ld_lane;
        case (size_q)
            2'd0: begin
                ld_data = unsigned_q ? {24'd0, ld_lane[7:0]}
                                     : {{24{ld_lane[7]}}, ld_lane[7:0]};
            end
            2'd1: begin
                ld_data = unsigned_q ? {16'd0, ld_lane[15:0]}
                                     : {{16{ld_lane[15]}}, ld_lane[15:0]};
            end
            default: begin
                ld_data = ld_lane;
            end
        endcase
    end

    // Outputs decoded from state and latched fields
    always_comb begin
        in_ready       = (state == S_IDLE);
        mem_req_valid  = (state == S_REQ);
        mem_req_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
        mem_req_wdata  = st_data;
        mem_req_wen    = (state == S_REQ) && is_store_q;
        mem_req_wmask  = ((state == S_REQ) && is_store_q) ? st_mask : 4'b0000;
        mem_resp_ready = (state == S_WAIT);
        rf_wen         = (state == S_WB) && (rd_q != '0);
        rf_waddr       = rd_q;
        rf_wdata       = ld_data;
        done           = (state == S_WB) || store_done_q;
        err            = err_q;
        dbg_state      = state;
    end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Bench for ysyx_24100005_lsu: a table of commands with expected bus and
// register-file outcomes, a memory model with programmable stalls, a monitor
// that pops expectations as the DUT produces them, plus hand-written reset and
// restart sequences.
module tb_ysyx_24100005_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_is_store;
    logic        in_unsigned;
    logic [1:0]  in_size;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    ysyx_24100005_lsu #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_is_store(in_is_store), .in_unsigned(in_unsigned), .in_size(in_size), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wen(mem_req_wen), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected bus requests {wen, addr, wmask, wdata} and completions
    // {done, err, rf_wen, rf_waddr, rf_wdata}
    logic [68:0] req_q[$];
    logic [39:0] exp_q[$];

    // ---------------- memory model ----------------
    int          req_stall  = 0;
    int          resp_stall = 0;
    logic [31:0] resp_word  = 32'd0;
    bit          mem_manual = 1'b0;
    bit          noise_en   = 1'b0;
    int          rcnt = 0;
    int          scnt = 0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_manual) begin
                if (mem_req_valid) begin
                    mem_req_ready = (rcnt >= req_stall);
                    rcnt++;
                end else begin
                    mem_req_ready = 1'b0;
                    rcnt = 0;
                end
                if (mem_resp_ready) begin
                    mem_resp_valid = (scnt >= resp_stall);
                    mem_resp_rdata = mem_resp_valid ? resp_word : $urandom();
                    scnt++;
                end else begin
                    scnt = 0;
                    mem_resp_valid = noise_en && ($urandom_range(0, 3) == 0);
                    mem_resp_rdata = $urandom();
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          hold_pend = 1'b0;
    logic [69:0] hold_val;

    always @(negedge clk) begin
        logic [68:0] rexp;
        logic [39:0] cexp;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("req_stable", {mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask, mem_req_wdata}, hold_val);
            end
            hold_pend = mem_req_valid && !mem_req_ready;
            hold_val  = {mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask, mem_req_wdata};
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    rexp = req_q.pop_front();
                    check("mem_req", {mem_req_wen, mem_req_addr, mem_req_wmask,
                                      mem_req_wen ? mem_req_wdata : 32'd0}, rexp);
                end
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("completion_unexpected", {done, err, rf_wen}, 0);
                end else begin
                    cexp = exp_q.pop_front();
                    check("completion", {done, err, rf_wen, rf_wen ? rf_waddr : 5'd0,
                                         rf_wen ? rf_wdata : 32'd0}, cexp);
                end
            end
            if (rf_wen && !done) begin
                check("rf_wen_without_done", 1, 0);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic        uns;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] resp;
        int          rs;
        int          ps;
        logic        e_err;
        logic [3:0]  e_mask;
        logic [31:0] e_mwdata;
        logic        e_rfw;
        logic [31:0] e_rfd;
    } vec_t;

    vec_t vt[$];

    task automatic drive_cmd(input logic st, input logic uns, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        in_is_store = st;
        in_unsigned = uns;
        in_size     = size;
        in_addr     = addr;
        in_wdata    = wdata;
        in_rd       = rd;
        in_valid    = 1'b1;
    endtask

    task automatic scramble_inputs;
        in_valid    = 1'b0;
        in_addr     = $urandom();
        in_wdata    = $urandom();
        in_rd       = 5'($urandom_range(0, 31));
        in_size     = 2'($urandom_range(0, 3));
        in_is_store = 1'($urandom_range(0, 1));
        in_unsigned = 1'($urandom_range(0, 1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  acc;
        bit  seen;
        int  lat;
        logic [31:0] eaddr;
        eaddr = {v.addr[31:2], 2'b00};
        req_stall  = v.rs;
        resp_stall = v.ps;
        resp_word  = v.resp;
        if (!v.e_err) begin
            req_q.push_back({v.st, eaddr, v.e_mask, v.e_mwdata});
        end
        exp_q.push_back({!v.e_err, v.e_err, v.e_rfw, v.e_rfw ? v.rd : 5'd0, v.e_rfw ? v.e_rfd : 32'd0});
        @(posedge clk);
        #1;
        drive_cmd(v.st, v.uns, v.size, v.addr, v.wdata, v.rd);
        seen = 1'b0;
        acc  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                acc  = cyc;
                break;
            end
        end
        check($sformatf("accept[%0d]", idx), seen, 1);
        @(posedge clk);
        #1;
        scramble_inputs();
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1'b1;
                lat  = cyc - acc;
                break;
            end
        end
        check($sformatf("finished[%0d]", idx), seen, 1);
        if (seen) begin
            check($sformatf("latency[%0d]", idx), lat, v.e_err ? 1 : 3 + v.rs + v.ps);
        end
        @(negedge clk);
        check($sformatf("idle_after[%0d]", idx), {in_ready, dbg_state}, {1'b1, 2'd0});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  k;
        bit  seen;
        rst_n = 1'b0;
        scramble_inputs();

        // st uns size addr wdata rd resp rs ps | err mask mwdata rfw rfd
        vt.push_back('{1'b0, 1'b0, 2'd2, 32'h80000004, 32'h0, 5'd5,  32'hDEADBEEF, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF});
        vt.push_back('{1'b0, 1'b0, 2'd0, 32'h80000003, 32'h0, 5'd7,  32'h80FF0011, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80});
        vt.push_back('{1'b0, 1'b1, 2'd0, 32'h80000003, 32'h0, 5'd7,  32'h80FF0011, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h00000080});
        vt.push_back('{1'b1, 1'b0, 2'd1, 32'h80000002, 32'h1234ABCD, 5'd3, 32'h0, 0, 0, 1'b0, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd2, 32'h80000001, 32'h0, 5'd6,  32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd0, 32'h00000010, 32'h0, 5'd1,  32'h123456F0, 5, 3, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hFFFFFFF0});
        vt.push_back('{1'b0, 1'b0, 2'd1, 32'h00000102, 32'h0, 5'd2,  32'h80017FFF, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hFFFF8001});
        vt.push_back('{1'b0, 1'b1, 2'd1, 32'h00000100, 32'h0, 5'd31, 32'h8001F234, 2, 1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0000F234});
        vt.push_back('{1'b1, 1'b0, 2'd0, 32'h00000201, 32'hAAAABB5C, 5'd4, 32'h0, 1, 4, 1'b0, 4'b0010, 32'h5C5C5C5C, 1'b0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 2'd2, 32'h00000300, 32'hCAFEF00D, 5'd9, 32'h0, 0, 2, 1'b0, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd2, 32'h00000400, 32'h0, 5'd0,  32'h12345678, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 2'd1, 32'h00000203, 32'h0BADBEEF, 5'd8, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd3, 32'h00000000, 32'h0, 5'd8,  32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 2'd0, 32'h00000502, 32'h0, 5'd10, 32'h00AB0000, 3, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h000000AB});
        vt.push_back('{1'b0, 1'b0, 2'd1, 32'h00000506, 32'h0, 5'd11, 32'h7FFE0000, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h00007FFE});
        vt.push_back('{1'b1, 1'b1, 2'd0, 32'h00000603, 32'h00000011, 5'd12, 32'h0, 0, 0, 1'b0, 4'b1000, 32'h11111111, 1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd2, 32'h00000002, 32'h0, 5'd13, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 2'd1, 32'h00000001, 32'h0, 5'd14, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0});

        // Reset values while rst_n is held low
        #12;
        check("reset_outputs",
              {dbg_state, in_ready, mem_req_valid, mem_resp_ready, rf_wen, done, err,
               mem_req_wen, mem_req_wmask, rf_waddr, mem_req_addr},
              {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: spurious responses are offered outside WAIT throughout
        noise_en = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i], i);
        end
        noise_en = 1'b0;

        // Reset while waiting for a response, then a late response
        @(posedge clk);
        #1;
        mem_manual     = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        req_q.push_back({1'b0, 32'h00000700, 4'b0000, 32'h0});
        drive_cmd(1'b0, 1'b0, 2'd2, 32'h00000700, 32'h0, 5'd9);
        @(posedge clk);
        #1;
        scramble_inputs();
        seen = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_wait", seen, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("reset_mid_wait",
              {dbg_state, in_ready, mem_req_valid, mem_resp_ready, rf_wen, done, err,
               mem_req_wen, mem_req_wmask, rf_waddr, mem_req_addr},
              {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0});
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h00000055;
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("late_resp_ignored[%0d]", k), {dbg_state, rf_wen, done}, {2'd0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_manual     = 1'b0;

        // Command waiting at reset release is taken on the first rising edge
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        req_stall  = 0;
        resp_stall = 0;
        resp_word  = 32'h0BADF00D;
        req_q.push_back({1'b0, 32'h00000800, 4'b0000, 32'h0});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 5'd4, 32'h0BADF00D});
        drive_cmd(1'b0, 1'b0, 2'd2, 32'h00000800, 32'h0, 5'd4);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("accept_after_release", dbg_state, 2'd1);
        scramble_inputs();
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1'b1;
                break;
            end
        end
        check("release_cmd_finished", seen, 1);
        repeat (3) @(negedge clk);

        check("req_q_drained", req_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, required completion", cyc);
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_LSU

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, register-file write-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed at 32 (bus, register and data width).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  command handshake from execute stage.
REQ-006 in_addr, in_wdata  input  32 each  byte address; store data (low bits significant).
REQ-007 in_is_store, in_unsigned  input  1 each  store(1)/load(0); zero-extend(1)/sign-extend(0) load.
REQ-008 in_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned).
REQ-009 in_rd  input  RF_ADDR_WIDTH  load destination register.
REQ-010 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-011 mem_req_addr, mem_req_wdata  output  32 each  word-aligned address ({addr[31:2],2'b00}); lane-shifted store data.
REQ-012 mem_req_wen, mem_req_wmask  output  1 / 4  write enable; byte-lane mask.
REQ-013 mem_resp_valid / mem_resp_ready  input / output  1 / 1  response handshake; mem_resp_rdata input 32 word read data.
REQ-014 rf_wen, rf_waddr, rf_wdata  output  1 / RF_ADDR_WIDTH / 32  register-file write port.
REQ-015 done, err  output  1 each  one-cycle completion pulse; one-cycle misalignment pulse.

Function
REQ-016 SHALL implement FSM IDLE, REQ, WAIT, WB; in_ready=1 only in IDLE.
REQ-017 IDLE: on in_valid&in_ready, SHALL latch all in_* fields; aligned -> REQ, misaligned -> IDLE with err=1 next cycle, no bus traffic, no rf write.
REQ-018 Misaligned SHALL mean: size=1 and addr[0]=1; size=2 and addr[1:0]!=0; size=3.
REQ-019 REQ: mem_req_valid=1, request fields held stable until mem_req_ready sampled high; then -> WAIT.
REQ-020 WAIT: mem_resp_ready=1; on mem_resp_valid: load -> WB, store -> IDLE with done=1 next cycle; mem_resp_ready=0 in all other states.
REQ-021 WB: rf_wen=1 for exactly one cycle (0 when rd=0), done=1 same cycle, -> IDLE.
REQ-022 Store mask SHALL be byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; wdata byte replicated x4, half x2, word as-is.
REQ-023 Load data SHALL be extracted from lane addr[1:0] of registered response, then sign- or zero-extended per in_unsigned.
REQ-024 Minimum latency (mem_req_ready and mem_resp_valid both high on first opportunity): load done 3 cycles after accept, store 3 cycles after accept.
REQ-025 SHALL tolerate unbounded mem_req_ready / mem_resp_valid stall without timeout; mem_resp_valid outside WAIT SHALL be ignored.
REQ-026 Back-to-back: next command SHALL be accepted in the cycle after done/err (IDLE re-entry).

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE; in_ready=1; mem_req_valid, mem_resp_ready, rf_wen, done, err, mem_req_wen, mem_req_wmask all 0; latched fields 0.
REQ-028 rst_n asserted mid-transaction SHALL abandon it with no rf write and no done pulse; first command after rst_n release accepted on the first rising edge.

Verification
REQ-029 Load word addr 0x80000004, rd=5, resp 0xDEADBEEF, ready/valid immediate -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, done, 3 cycles after accept.
REQ-030 Load byte signed addr 0x80000003, resp 0x80FF0011 -> rf_wdata=0xFFFFFF80; same with in_unsigned=1 -> 0x00000080.
REQ-031 Store half addr 0x80000002, wdata 0x1234ABCD -> mem_req_addr=0x80000000, wmask=4'b1100, wdata=0xABCDABCD, wen=1, done, rf_wen never 1.
REQ-032 Load word addr 0x80000001 -> err pulse 1 cycle after accept, mem_req_valid never 1, in_ready back to 1.
REQ-033 mem_req_ready held 0 for 5 cycles then 1, mem_resp_valid delayed 3 cycles -> request fields stable throughout, done exactly once.
REQ-034 rst_n low while in WAIT, then late mem_resp_valid -> state IDLE, no rf_wen, no done; load rd=0 -> rf_wen stays 0, done=1.
